// File: rtl/l2_axi_line_reader_if.sv
// Fill-request, fill-response and AXI4 read-channel bundle
// for the L2 line reader.
interface l2_axi_line_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [25:0]           req_line;
  logic [3:0]            req_id;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [3:0]            rsp_id;
  logic [511:0]          rsp_data;

  logic                  m_arvalid;
  logic                  s_arready;
  logic [31:0]           m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic [3:0]            m_arcache;

  logic                  s_rvalid;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic                  m_rready;

  modport master (
    input  req_valid, req_line, req_id,
    input  rsp_ready,
    input  s_arready, s_rvalid, s_rdata,
    output req_ready,
    output rsp_valid, rsp_id, rsp_data,
    output m_arvalid, m_araddr, m_arlen,
    output m_arsize, m_arburst, m_arcache,
    output m_rready
  );

  modport slave (
    output req_valid, req_line, req_id,
    output rsp_ready,
    output s_arready, s_rvalid, s_rdata,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_data,
    input  m_arvalid, m_araddr, m_arlen,
    input  m_arsize, m_arburst, m_arcache,
    input  m_rready
  );
endinterface

// File: rtl/l2_axi_line_reader.sv
// L2 miss-path line reader: one INCR burst per fill,
// beats assembled MSW-first into a 512-bit line.
module l2_axi_line_reader #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  l2_axi_line_reader_if.master          bus
);

  localparam int LINE_BITS   = 512;
  localparam int BURST_BEATS = LINE_BITS / DATA_WIDTH;
  localparam int CW          = $clog2(BURST_BEATS);

  localparam logic [1:0]    AXI_BURST_INCR = 2'b01;
  localparam logic [3:0]    AR_CACHE       = 4'b0011;
  localparam logic [7:0]    AR_LEN         = 8'(BURST_BEATS - 1);
  localparam logic [2:0]    AR_SIZE        = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [CW-1:0] LAST_BEAT      = CW'(BURST_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [25:0]        r_line;
  logic [3:0]         r_id;
  logic [CW-1:0]      r_cnt;
  logic [LINE_BITS-1:0] r_data;

  logic w_idle;
  logic w_addr;
  logic w_data;
  logic w_resp;

  assign w_idle = (r_state == S_IDLE);
  assign w_addr = (r_state == S_ADDR);
  assign w_data = (r_state == S_DATA);
  assign w_resp = (r_state == S_RESP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.req_valid) w_next = S_ADDR;
      S_ADDR: if (bus.s_arready) w_next = S_DATA;
      S_DATA: begin
        if (bus.s_rvalid && r_cnt == LAST_BEAT)
          w_next = S_RESP;
      end
      S_RESP: if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Beat k lands in the k-th word from the top of the line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_line <= '0;
      r_id   <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else begin
      if (w_idle && bus.req_valid) begin
        r_line <= bus.req_line;
        r_id   <= bus.req_id;
        r_cnt  <= '0;
      end
      if (w_data && bus.s_rvalid) begin
        r_cnt <= r_cnt + CW'(1);
        for (int i = 0; i < BURST_BEATS; i++) begin
          if (r_cnt == CW'(i))
            r_data[LINE_BITS-1-i*DATA_WIDTH -: DATA_WIDTH]
              <= bus.s_rdata;
        end
      end
    end
  end

  assign bus.req_ready = w_idle;
  assign bus.m_arvalid = w_addr;
  assign bus.m_rready  = w_data;
  assign bus.rsp_valid = w_resp;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_data;

  // AR fields are zero outside ADDR so idle/reset buses stay quiet.
  assign bus.m_araddr  = w_addr ? {r_line, 6'b0} : '0;
  assign bus.m_arlen   = w_addr ? AR_LEN         : '0;
  assign bus.m_arsize  = w_addr ? AR_SIZE        : '0;
  assign bus.m_arburst = w_addr ? AXI_BURST_INCR : '0;
  assign bus.m_arcache = w_addr ? AR_CACHE       : '0;

endmodule
